// File: rtl/fp_add_sub_param.sv
// Parametrised IEEE-754 adder/subtractor, round-to-nearest-even, with A/B store/ack
// input handshake and a SUM valid/ack output handshake; one operation in flight.
module fp_add_sub_param #(
    parameter int EXP_W = 11,
    parameter int MAN_W = 52
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   A_store_bit,
    input  logic [EXP_W+MAN_W:0]   A,
    output logic                   A_acknowledgment,
    input  logic                   B_store_bit,
    input  logic [EXP_W+MAN_W:0]   B,
    input  logic                   Op,
    output logic                   B_acknowledgment,
    output logic [EXP_W+MAN_W:0]   SUM,
    output logic [3:0]             Flags,
    output logic                   SUM_store_bit,
    input  logic                   SUM_acknowledgment
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int SW = MAN_W + 4;
    localparam logic [EXP_W:0] EMAX = {1'b0, {EXP_W{1'b1}}};
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    localparam logic [3:0] S_STORE_A = 4'd0, S_STORE_B = 4'd1, S_UNPACK = 4'd2,
                           S_SPECIAL = 4'd3, S_ALIGN   = 4'd4, S_ADD    = 4'd5,
                           S_NORM    = 4'd6, S_ROUND   = 4'd7, S_PACK   = 4'd8,
                           S_OUTPUT  = 4'd9;

    logic [3:0]       state_q, state_d;
    logic             a_ack_q, a_ack_d, b_ack_q, b_ack_d, vld_q, vld_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d, res_q, res_d;
    logic             op_q, op_d;
    logic [3:0]       flags_q, flags_d;
    logic             sa_q, sa_d, sb_q, sb_d;
    logic [EXP_W-1:0] ea_q, ea_d, eb_q, eb_d;
    logic [MAN_W:0]   ma_q, ma_d, mb_q, mb_d;
    logic             sgn_q, sgn_d, zsgn_q, zsgn_d, sub_q, sub_d;
    logic [EXP_W:0]   exp_q, exp_d;
    logic [SW-1:0]    big_q, big_d, small_q, small_d, norm_q, norm_d;
    logic [SW:0]      acc_q, acc_d;
    logic [MAN_W:0]   man_q, man_d;
    logic             inx_q, inx_d;

    logic [EXP_W-1:0] a_exp, b_exp, e_big, e_small, e_diff;
    logic [MAN_W-1:0] a_frac, b_frac;
    logic             a_nan, b_nan, a_snan, b_snan, a_inf, b_inf;
    logic             a_big, s_big, inc, zsign;
    logic [MAN_W:0]   sig_big, sig_small;
    logic [SW-1:0]    small_ext;
    logic [31:0]      sh, lz, lim, nsh;
    logic [MAN_W+1:0] rnd;

    assign a_exp  = a_q[MAN_W +: EXP_W];
    assign b_exp  = b_q[MAN_W +: EXP_W];
    assign a_frac = a_q[MAN_W-1:0];
    assign b_frac = b_q[MAN_W-1:0];
    assign a_nan  = (a_exp == '1) && (a_frac != '0);
    assign b_nan  = (b_exp == '1) && (b_frac != '0);
    assign a_snan = a_nan && !a_frac[MAN_W-1];
    assign b_snan = b_nan && !b_frac[MAN_W-1];
    assign a_inf  = (a_exp == '1) && (a_frac == '0);
    assign b_inf  = (b_exp == '1) && (b_frac == '0);

    function automatic logic [31:0] clz(input logic [SW-1:0] v);
        clz = 32'(SW);
        for (int unsigned i = 0; i < SW; i++)
            if (v[i]) clz = 32'(SW - 1) - 32'(i);
    endfunction

    always_comb begin
        state_d = state_q;  a_ack_d = a_ack_q;  b_ack_d = b_ack_q;  vld_d = vld_q;
        a_d = a_q;  b_d = b_q;  op_d = op_q;  res_d = res_q;  flags_d = flags_q;
        sa_d = sa_q;  sb_d = sb_q;  ea_d = ea_q;  eb_d = eb_q;  ma_d = ma_q;  mb_d = mb_q;
        sgn_d = sgn_q;  zsgn_d = zsgn_q;  sub_d = sub_q;  exp_d = exp_q;
        big_d = big_q;  small_d = small_q;  acc_d = acc_q;  norm_d = norm_q;
        man_d = man_q;  inx_d = inx_q;
        a_big = 1'b0;  s_big = 1'b0;  e_big = '0;  e_small = '0;  e_diff = '0;
        sig_big = '0;  sig_small = '0;  small_ext = '0;  sh = '0;  lz = '0;
        lim = '0;  nsh = '0;  inc = 1'b0;  rnd = '0;  zsign = 1'b0;

        case (state_q)
            S_STORE_A: begin
                if (!a_ack_q) a_ack_d = 1'b1;
                else if (A_store_bit) begin
                    a_d = A;  a_ack_d = 1'b0;  state_d = S_STORE_B;
                end
            end
            S_STORE_B: begin
                if (!b_ack_q) b_ack_d = 1'b1;
                else if (B_store_bit) begin
                    b_d = B;  op_d = Op;  b_ack_d = 1'b0;  state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                sa_d = a_q[W-1];
                sb_d = b_q[W-1] ^ op_q;
                ea_d = (a_exp == '0) ? EXP_W'(1) : a_exp;
                eb_d = (b_exp == '0) ? EXP_W'(1) : b_exp;
                ma_d = {a_exp != '0, a_frac};
                mb_d = {b_exp != '0, b_frac};
                state_d = S_SPECIAL;
            end
            S_SPECIAL: begin
                state_d = S_OUTPUT;
                vld_d   = 1'b1;
                if (a_nan || b_nan) begin
                    res_d = QNAN;  flags_d = {a_snan | b_snan, 3'b000};
                end else if (a_inf && b_inf && (sa_q != sb_q)) begin
                    res_d = QNAN;  flags_d = 4'b1000;
                end else if (a_inf || b_inf) begin
                    res_d = {a_inf ? sa_q : sb_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    flags_d = 4'b0000;
                end else begin
                    state_d = S_ALIGN;  vld_d = 1'b0;
                end
            end
            S_ALIGN: begin
                a_big     = {ea_q, ma_q} >= {eb_q, mb_q};
                e_big     = a_big ? ea_q : eb_q;
                e_small   = a_big ? eb_q : ea_q;
                sig_big   = a_big ? ma_q : mb_q;
                sig_small = a_big ? mb_q : ma_q;
                s_big     = a_big ? sa_q : sb_q;
                e_diff    = e_big - e_small;
                sh        = 32'(e_diff);
                small_ext = {sig_small, 3'b000};
                // Bits shifted past the sticky position collapse into it.
                if (sh >= 32'(MAN_W + 3))
                    small_d = {{(SW-1){1'b0}}, |sig_small};
                else
                    small_d = (small_ext >> sh) |
                              {{(SW-1){1'b0}}, |(small_ext & ~({SW{1'b1}} << sh))};
                big_d   = {sig_big, 3'b000};
                exp_d   = {1'b0, e_big};
                sgn_d   = s_big;
                sub_d   = sa_q ^ sb_q;
                zsgn_d  = sa_q & sb_q;
                state_d = S_ADD;
            end
            S_ADD: begin
                acc_d   = sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                                : ({1'b0, big_q} + {1'b0, small_q});
                state_d = S_NORM;
            end
            S_NORM: begin
                if (acc_q[SW]) begin
                    norm_d = {acc_q[SW:2], acc_q[1] | acc_q[0]};
                    exp_d  = exp_q + 1'b1;
                end else begin
                    // Left shift stops at exponent 1 so tiny results come out subnormal.
                    lz     = clz(acc_q[SW-1:0]);
                    lim    = 32'(exp_q) - 32'd1;
                    nsh    = (lz < lim) ? lz : lim;
                    norm_d = acc_q[SW-1:0] << nsh;
                    exp_d  = exp_q - (EXP_W+1)'(nsh);
                end
                state_d = S_ROUND;
            end
            S_ROUND: begin
                inc   = norm_q[2] & (norm_q[1] | norm_q[0] | norm_q[3]);
                rnd   = {1'b0, norm_q[SW-1:3]} + {{(MAN_W+1){1'b0}}, inc};
                inx_d = |norm_q[2:0];
                if (rnd[MAN_W+1]) begin
                    man_d = rnd[MAN_W+1:1];
                    exp_d = exp_q + 1'b1;
                end else begin
                    man_d = rnd[MAN_W:0];
                end
                state_d = S_PACK;
            end
            S_PACK: begin
                zsign = (man_q == '0) ? zsgn_q : sgn_q;
                if (exp_q >= EMAX) begin
                    res_d = {sgn_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};  flags_d = 4'b0101;
                end else if (!man_q[MAN_W]) begin
                    res_d = {zsign, {EXP_W{1'b0}}, man_q[MAN_W-1:0]};
                    flags_d = {2'b00, inx_q, inx_q};
                end else begin
                    res_d = {sgn_q, exp_q[EXP_W-1:0], man_q[MAN_W-1:0]};
                    flags_d = {3'b000, inx_q};
                end
                vld_d   = 1'b1;
                state_d = S_OUTPUT;
            end
            S_OUTPUT: begin
                if (SUM_acknowledgment) begin
                    vld_d = 1'b0;  state_d = S_STORE_A;
                end
            end
            default: state_d = S_STORE_A;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_STORE_A;  a_ack_q <= 1'b0;  b_ack_q <= 1'b0;  vld_q <= 1'b0;
            a_q <= '0;  b_q <= '0;  op_q <= 1'b0;  res_q <= '0;  flags_q <= '0;
            sa_q <= 1'b0;  sb_q <= 1'b0;  ea_q <= '0;  eb_q <= '0;  ma_q <= '0;  mb_q <= '0;
            sgn_q <= 1'b0;  zsgn_q <= 1'b0;  sub_q <= 1'b0;  exp_q <= '0;
            big_q <= '0;  small_q <= '0;  acc_q <= '0;  norm_q <= '0;
            man_q <= '0;  inx_q <= 1'b0;
        end else begin
            state_q <= state_d;  a_ack_q <= a_ack_d;  b_ack_q <= b_ack_d;  vld_q <= vld_d;
            a_q <= a_d;  b_q <= b_d;  op_q <= op_d;  res_q <= res_d;  flags_q <= flags_d;
            sa_q <= sa_d;  sb_q <= sb_d;  ea_q <= ea_d;  eb_q <= eb_d;  ma_q <= ma_d;  mb_q <= mb_d;
            sgn_q <= sgn_d;  zsgn_q <= zsgn_d;  sub_q <= sub_d;  exp_q <= exp_d;
            big_q <= big_d;  small_q <= small_d;  acc_q <= acc_d;  norm_q <= norm_d;
            man_q <= man_d;  inx_q <= inx_d;
        end
    end

    assign A_acknowledgment = a_ack_q;
    assign B_acknowledgment = b_ack_q;
    assign SUM              = res_q;
    assign Flags            = flags_q;
    assign SUM_store_bit    = vld_q;

endmodule

// File: tb/tb_fp_add_sub_param.sv
// Directed-vector bench for fp_add_sub_param at double precision: results, flags,
// latency, output backpressure and asynchronous reset in mid-operation.
module tb_fp_add_sub_param;
    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        A_store_bit = 1'b0, B_store_bit = 1'b0, Op = 1'b0;
    logic        SUM_acknowledgment = 1'b0;
    logic [63:0] A = '0, B = '0;
    logic [63:0] SUM;
    logic [3:0]  Flags;
    logic        A_acknowledgment, B_acknowledgment, SUM_store_bit;

    int n_vec = 0;
    int n_bad = 0;

    fp_add_sub_param #(.EXP_W(11), .MAN_W(52)) dut (
        .Clock(Clock), .Reset(Reset),
        .A_store_bit(A_store_bit), .A(A), .A_acknowledgment(A_acknowledgment),
        .B_store_bit(B_store_bit), .B(B), .Op(Op), .B_acknowledgment(B_acknowledgment),
        .SUM(SUM), .Flags(Flags), .SUM_store_bit(SUM_store_bit),
        .SUM_acknowledgment(SUM_acknowledgment)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Handshakes A then B; returns #1 after the B-capture edge.
    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic op);
        int k;
        k = 0;
        while (!A_acknowledgment && k < 20) begin @(posedge Clock); #1; k++; end
        chk("a_ack", {63'd0, A_acknowledgment}, 64'd1);
        A = a;  A_store_bit = 1'b1;
        @(posedge Clock); #1;
        A_store_bit = 1'b0;
        k = 0;
        while (!B_acknowledgment && k < 20) begin @(posedge Clock); #1; k++; end
        chk("b_ack", {63'd0, B_acknowledgment}, 64'd1);
        B = b;  Op = op;  B_store_bit = 1'b1;
        @(posedge Clock); #1;
        B_store_bit = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!SUM_store_bit && lat < 40) begin @(posedge Clock); #1; lat++; end
        chk("sum_vld", {63'd0, SUM_store_bit}, 64'd1);
    endtask

    task automatic take_result();
        SUM_acknowledgment = 1'b1;
        @(posedge Clock); #1;
        SUM_acknowledgment = 1'b0;
        chk("sum_vld_clr", {63'd0, SUM_store_bit}, 64'd0);
    endtask

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        op;
        logic [63:0] s;
        logic [3:0]  f;
        int          lat;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int lat;
        vecs[0]  = '{64'h3FF0000000000000, 64'h4000000000000000, 1'b0, 64'h4008000000000000, 4'b0000, 7};
        vecs[1]  = '{64'h3FF0000000000000, 64'h3FF0000000000000, 1'b1, 64'h0000000000000000, 4'b0000, 7};
        vecs[2]  = '{64'h8000000000000000, 64'h8000000000000000, 1'b0, 64'h8000000000000000, 4'b0000, 7};
        vecs[3]  = '{64'h7FF0000000000000, 64'hFFF0000000000000, 1'b0, 64'h7FF8000000000000, 4'b1000, 2};
        vecs[4]  = '{64'h7FF0000000000001, 64'h3FF0000000000000, 1'b0, 64'h7FF8000000000000, 4'b1000, 2};
        vecs[5]  = '{64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF, 1'b0, 64'h7FF0000000000000, 4'b0101, 7};
        vecs[6]  = '{64'h3FF0000000000000, 64'h3CA0000000000000, 1'b0, 64'h3FF0000000000000, 4'b0001, 7};
        vecs[7]  = '{64'h0000000000000001, 64'h0000000000000001, 1'b0, 64'h0000000000000002, 4'b0000, 7};
        vecs[8]  = '{64'h0010000000000000, 64'h0000000000000001, 1'b1, 64'h000FFFFFFFFFFFFF, 4'b0000, 7};
        vecs[9]  = '{64'h4000000000000000, 64'h3FF0000000000000, 1'b1, 64'h3FF0000000000000, 4'b0000, 7};
        vecs[10] = '{64'h7FF0000000000000, 64'hFFF0000000000000, 1'b1, 64'h7FF0000000000000, 4'b0000, 2};
        vecs[11] = '{64'h3FF0000000000000, 64'h3CA0000000000001, 1'b0, 64'h3FF0000000000001, 4'b0001, 7};

        repeat (2) @(posedge Clock);
        #1;
        chk("rst_a_ack", {63'd0, A_acknowledgment}, 64'd0);
        chk("rst_b_ack", {63'd0, B_acknowledgment}, 64'd0);
        chk("rst_vld",   {63'd0, SUM_store_bit}, 64'd0);
        chk("rst_sum",   SUM, 64'd0);
        chk("rst_flags", {60'd0, Flags}, 64'd0);
        Reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].op);
            wait_result(lat);
            chk($sformatf("v%0d_sum", i), SUM, vecs[i].s);
            chk($sformatf("v%0d_flags", i), {60'd0, Flags}, {60'd0, vecs[i].f});
            chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
            take_result();
        end

        // Output backpressure: result must stay put while unacknowledged.
        send(64'h3FF0000000000000, 64'h4000000000000000, 1'b0);
        wait_result(lat);
        for (int c = 0; c < 10; c++) begin
            @(posedge Clock); #1;
            chk($sformatf("hold%0d_vld", c), {63'd0, SUM_store_bit}, 64'd1);
            chk($sformatf("hold%0d_sum", c), SUM, 64'h4008000000000000);
        end
        take_result();

        // Asynchronous reset while the second operation sits in ALIGN.
        send(64'h3FF0000000000000, 64'h4000000000000000, 1'b0);
        @(posedge Clock); #1;
        @(posedge Clock); #1;
        Reset = 1'b0;
        #1;
        chk("mid_rst_a_ack", {63'd0, A_acknowledgment}, 64'd0);
        chk("mid_rst_b_ack", {63'd0, B_acknowledgment}, 64'd0);
        chk("mid_rst_vld",   {63'd0, SUM_store_bit}, 64'd0);
        chk("mid_rst_sum",   SUM, 64'd0);
        chk("mid_rst_flags", {60'd0, Flags}, 64'd0);
        repeat (2) @(posedge Clock);
        #1;
        chk("mid_rst_vld_hold", {63'd0, SUM_store_bit}, 64'd0);
        Reset = 1'b1;

        send(64'h3FF0000000000000, 64'h3CA0000000000000, 1'b0);
        wait_result(lat);
        chk("post_rst_sum", SUM, 64'h3FF0000000000000);
        chk("post_rst_flags", {60'd0, Flags}, 64'h1);
        chk("post_rst_lat", 64'(lat), 64'd7);
        take_result();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/fp_add_sub_param.md
Name: fp_add_sub_param

Overview:
Parametrised IEEE-754 binary floating-point adder/subtractor with round-to-nearest-even, full special-case handling, subnormal support and exception flags. It is the next generation of the team's double-precision adder and is generic in exponent and mantissa width. It keeps the A/B store/acknowledge input handshake, adds a per-operation add/subtract mode, and adds a true output handshake with backpressure. It sits in front of the Halley-method square-root datapath.

Parameters:
EXP_W, 11, exponent field width (minimum 3); bias is 2^(EXP_W-1)-1.
MAN_W, 52, stored fraction width (minimum 2); W = 1+EXP_W+MAN_W.

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  asynchronous, active-low reset (Reset=0 resets)
A_store_bit  input  1  producer offers A
A  input  W  operand A
A_acknowledgment  output  1  block ready to take A
B_store_bit  input  1  producer offers B and Op
B  input  W  operand B
Op  input  1  0 = A+B, 1 = A-B; sampled with B
B_acknowledgment  output  1  block ready to take B
SUM  output  W  result
Flags  output  4  {invalid, overflow, underflow, inexact}; valid with SUM
SUM_store_bit  output  1  SUM/Flags valid
SUM_acknowledgment  input  1  consumer accepts SUM

Behaviour:
- Reset (async, Reset=0):
  - State goes to STORE_A.
  - A_acknowledgment, B_acknowledgment, SUM_store_bit, SUM and Flags all clear to 0.
  - All internal registers clear.
  - An operation in flight is discarded, not completed.
- STORE_A:
  - A_acknowledgment is set on the first edge in this state.
  - A is captured on an edge where A_store_bit=1 and A_acknowledgment=1. On that edge A_acknowledgment clears and the state goes to STORE_B.
- STORE_B: same rule for B/Op with B_acknowledgment. The state then goes to UNPACK.
- UNPACK:
  - Split sign, exponent and fraction. Effective sign of B = B sign XOR Op.
  - Exponent field 0 means subnormal: hidden bit 0, exponent treated as 1. Otherwise hidden bit is 1.
- SPECIAL:
  - Any NaN input: result is canonical quiet NaN (sign 0, exponent all ones, fraction MSB 1, rest 0). invalid is set if either NaN is signalling (fraction MSB 0).
  - Inf with effective subtraction of Inf: canonical qNaN, invalid=1.
  - Otherwise, any Inf input: result is that Inf with its effective sign.
  - For all three cases the next state is OUTPUT. Otherwise the next state is ALIGN.
- ALIGN:
  - Swap so the larger magnitude is the first operand.
  - Shift the smaller significand right by the exponent difference in one cycle, keeping guard, round and sticky bits.
  - A shift of MAN_W+3 or more reduces it to sticky only.
- ADD: (MAN_W+4)-bit add or subtract of magnitudes. The result sign is the sign of the larger operand.
- NORMALIZE:
  - On carry-out, shift right 1 (OR the shifted bit into sticky) and increment the exponent.
  - Otherwise, shift left by leading-zero count in one cycle, limited so the exponent does not drop below 1 (this produces subnormals).
- ROUND:
  - Round to nearest even: increment if G & (R | S | LSB).
  - inexact = G|R|S.
  - Mantissa overflow from rounding renormalises (exponent +1).
- PACK:
  - Exponent ≥ all-ones: ±Inf, overflow=1, inexact=1.
  - Hidden bit 0 after rounding: exponent field is 0 (subnormal/zero). underflow = that condition AND inexact.
  - Exact zero magnitude: sign = (A sign AND effective B sign), so x−x gives +0 and (−0)+(−0) gives −0.
- OUTPUT:
  - SUM_store_bit=1; SUM and Flags are stable.
  - On an edge with SUM_acknowledgment=1, SUM_store_bit clears and the state returns to STORE_A.
  - SUM and Flags hold their last values until the next result.
  - SUM_acknowledgment is ignored outside OUTPUT.
- Latency, counted from the B-capture edge to the edge that sets SUM_store_bit:
  - Finite operands: exactly 7 edges.
  - NaN/Inf path: exactly 2 edges.
- Throughput: one operation per handshake sequence; no overlap. A_store_bit/B_store_bit asserted in any other state are ignored.

Test Plan:
- Default params, Op=0, A=0x3FF0000000000000, B=0x4000000000000000 -> SUM=0x4008000000000000, Flags=0000, SUM_store_bit 7 edges after B capture.
- Op=1, A=B=0x3FF0000000000000 -> SUM=0x0000000000000000, Flags=0000; Op=0, A=B=0x8000000000000000 -> SUM=0x8000000000000000.
- Op=0, A=0x7FF0000000000000, B=0xFFF0000000000000 -> SUM=0x7FF8000000000000, Flags=1000, 2-edge latency; A=0x7FF0000000000001 (signalling), B=0x3FF0000000000000 -> SUM=0x7FF8000000000000, Flags=1000.
- A=B=0x7FEFFFFFFFFFFFFF add -> SUM=0x7FF0000000000000, Flags=0101; A=0x3FF0000000000000, B=0x3CA0000000000000 -> SUM=0x3FF0000000000000, Flags=0001 (tie to even).
- Subnormals: A=B=0x0000000000000001 add -> SUM=0x0000000000000002, Flags=0000; A=0x0010000000000000, B=0x0000000000000001, Op=1 -> SUM=0x000FFFFFFFFFFFFF, Flags=0000.
- Hold SUM_acknowledgment=0 for 10 cycles -> SUM_store_bit and SUM stable throughout; assert Reset=0 mid-ALIGN of a second operation -> all outputs 0 immediately, next operation after release returns the correct result.
